// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Produces the PC/IF-ID freeze, inserts bubbles on stall/flush and counts stall cycles.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Hold,
    input  logic              Flush,
    input  logic              IF_ID_Valid,
    input  logic [REG_W-1:0]  IF_ID_RegRs,
    input  logic [REG_W-1:0]  IF_ID_RegRt,
    input  logic [REG_W-1:0]  IF_ID_RegRd,
    input  logic              IF_ID_ReadsRs,
    input  logic              IF_ID_ReadsRt,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              ID_MemWrite,
    input  logic              ID_MemToReg,
    input  logic              ID_ALUSrc,
    input  logic              ID_Halt,
    input  logic [3:0]        ID_ALUOp,
    input  logic [DATA_W-1:0] ID_RsData,
    input  logic [DATA_W-1:0] ID_RtData,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PC,
    output logic              ID_EX_Valid,
    output logic [REG_W-1:0]  ID_EX_RegRs,
    output logic [REG_W-1:0]  ID_EX_RegRt,
    output logic [REG_W-1:0]  ID_EX_RegRd,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_MemWrite,
    output logic              ID_EX_MemToReg,
    output logic              ID_EX_ALUSrc,
    output logic              ID_EX_Halt,
    output logic [3:0]        ID_EX_ALUOp,
    output logic [DATA_W-1:0] ID_EX_RsData,
    output logic [DATA_W-1:0] ID_EX_RtData,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PC,
    output logic              Stall,
    output logic [CNT_W-1:0]  StallCount
);

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  reg_rs;
        logic [REG_W-1:0]  reg_rt;
        logic [REG_W-1:0]  reg_rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic              halt;
        logic [3:0]        alu_op;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } ex_t;

    ex_t              ex_reg;
    ex_t              ex_next;
    ex_t              ex_capture;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic [REG_W-1:0] src_id [2];
    logic [1:0]       src_reads;
    logic [1:0]       src_hit;
    logic             store_data;
    logic             load_in_ex;
    logic             load_use;
    logic             stall_int;
    logic             bubble;

    assign src_id[0]    = IF_ID_RegRs;
    assign src_id[1]    = IF_ID_RegRt;
    assign src_reads[0] = IF_ID_ReadsRs;
    assign src_reads[1] = IF_ID_ReadsRt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src_hit
            assign src_hit[gi] = src_reads[gi] & (src_id[gi] == ex_reg.reg_rd);
        end
    endgenerate

    // Store data reaching MEM is forwarded MEM-to-MEM, so an Rt-only store dependency needs no stall.
    assign store_data = ID_MemWrite & ~src_hit[0];
    assign load_in_ex = ex_reg.valid & ex_reg.mem_read & (ex_reg.reg_rd != '0) & IF_ID_Valid;
    assign load_use   = load_in_ex & (src_hit[0] | (src_hit[1] & ~store_data));
    assign stall_int  = load_use & ~Flush & ~rst;
    assign bubble     = Flush | stall_int | ~IF_ID_Valid;

    always_comb begin
        ex_capture            = '0;
        ex_capture.valid      = 1'b1;
        ex_capture.reg_rs     = IF_ID_RegRs;
        ex_capture.reg_rt     = IF_ID_RegRt;
        ex_capture.reg_rd     = IF_ID_RegRd;
        ex_capture.reg_write  = ID_RegWrite;
        ex_capture.mem_read   = ID_MemRead;
        ex_capture.mem_write  = ID_MemWrite;
        ex_capture.mem_to_reg = ID_MemToReg;
        ex_capture.alu_src    = ID_ALUSrc;
        ex_capture.halt       = ID_Halt;
        ex_capture.alu_op     = ID_ALUOp;
        ex_capture.rs_data    = ID_RsData;
        ex_capture.rt_data    = ID_RtData;
        ex_capture.imm        = ID_Imm;
        ex_capture.pc         = ID_PC;
    end

    always_comb begin
        ex_next  = ex_reg;
        cnt_next = cnt_reg;
        if (!Hold) begin
            ex_next = bubble ? '0 : ex_capture;
            if (stall_int && (cnt_reg != '1)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            ex_reg  <= ex_next;
            cnt_reg <= cnt_next;
        end
    end

    assign ID_EX_Valid    = ex_reg.valid;
    assign ID_EX_RegRs    = ex_reg.reg_rs;
    assign ID_EX_RegRt    = ex_reg.reg_rt;
    assign ID_EX_RegRd    = ex_reg.reg_rd;
    assign ID_EX_RegWrite = ex_reg.reg_write;
    assign ID_EX_MemRead  = ex_reg.mem_read;
    assign ID_EX_MemWrite = ex_reg.mem_write;
    assign ID_EX_MemToReg = ex_reg.mem_to_reg;
    assign ID_EX_ALUSrc   = ex_reg.alu_src;
    assign ID_EX_Halt     = ex_reg.halt;
    assign ID_EX_ALUOp    = ex_reg.alu_op;
    assign ID_EX_RsData   = ex_reg.rs_data;
    assign ID_EX_RtData   = ex_reg.rt_data;
    assign ID_EX_Imm      = ex_reg.imm;
    assign ID_EX_PC       = ex_reg.pc;
    assign Stall          = stall_int;
    assign StallCount     = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus randomized traffic
// checked against an instruction-level model of the EX slot and stall counter.
module tb_id_ex_stage;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        alusrc;
        logic        halt;
        logic [3:0]  aluop;
        logic [15:0] rsdata;
        logic [15:0] rtdata;
        logic [15:0] imm;
        logic [15:0] pc;
    } instr_t;

    logic clk, rst, Hold, Flush;
    logic IF_ID_Valid, IF_ID_ReadsRs, IF_ID_ReadsRt;
    logic [3:0] IF_ID_RegRs, IF_ID_RegRt, IF_ID_RegRd;
    logic ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Halt;
    logic [3:0] ID_ALUOp;
    logic [15:0] ID_RsData, ID_RtData, ID_Imm, ID_PC;
    logic ID_EX_Valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
    logic ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Halt;
    logic [3:0] ID_EX_RegRs, ID_EX_RegRt, ID_EX_RegRd, ID_EX_ALUOp;
    logic [15:0] ID_EX_RsData, ID_EX_RtData, ID_EX_Imm, ID_EX_PC;
    logic Stall;
    logic [CW-1:0] StallCount;

    int tests_run = 0;
    int failures  = 0;

    instr_t m_ex;
    int     m_cnt;
    logic   obs_stall;
    logic   exp_stall;
    instr_t dut_ex;

    id_ex_stage #(.DATA_W(16), .REG_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Hold(Hold), .Flush(Flush),
        .IF_ID_Valid(IF_ID_Valid), .IF_ID_RegRs(IF_ID_RegRs), .IF_ID_RegRt(IF_ID_RegRt),
        .IF_ID_RegRd(IF_ID_RegRd), .IF_ID_ReadsRs(IF_ID_ReadsRs), .IF_ID_ReadsRt(IF_ID_ReadsRt),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
        .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc), .ID_Halt(ID_Halt),
        .ID_ALUOp(ID_ALUOp), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .ID_Imm(ID_Imm), .ID_PC(ID_PC),
        .ID_EX_Valid(ID_EX_Valid), .ID_EX_RegRs(ID_EX_RegRs), .ID_EX_RegRt(ID_EX_RegRt),
        .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg), .ID_EX_ALUSrc(ID_EX_ALUSrc),
        .ID_EX_Halt(ID_EX_Halt), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_RsData(ID_EX_RsData),
        .ID_EX_RtData(ID_EX_RtData), .ID_EX_Imm(ID_EX_Imm), .ID_EX_PC(ID_EX_PC),
        .Stall(Stall), .StallCount(StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        dut_ex          = '0;
        dut_ex.valid    = ID_EX_Valid;
        dut_ex.rs       = ID_EX_RegRs;
        dut_ex.rt       = ID_EX_RegRt;
        dut_ex.rd       = ID_EX_RegRd;
        dut_ex.regwrite = ID_EX_RegWrite;
        dut_ex.memread  = ID_EX_MemRead;
        dut_ex.memwrite = ID_EX_MemWrite;
        dut_ex.memtoreg = ID_EX_MemToReg;
        dut_ex.alusrc   = ID_EX_ALUSrc;
        dut_ex.halt     = ID_EX_Halt;
        dut_ex.aluop    = ID_EX_ALUOp;
        dut_ex.rsdata   = ID_EX_RsData;
        dut_ex.rtdata   = ID_EX_RtData;
        dut_ex.imm      = ID_EX_Imm;
        dut_ex.pc       = ID_EX_PC;
    end

    // A load in EX blocks the ID instruction if ID needs its result in EX: any Rs read,
    // or an Rt read that is not store data.
    function automatic bit model_load_use(input instr_t ex, input instr_t id, input bit rr_s, input bit rr_t);
        bit needs;
        needs = (rr_s && id.rs == ex.rd) || (rr_t && !id.memwrite && id.rt == ex.rd);
        return ex.valid && ex.memread && (ex.rd != 0) && id.valid && needs;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.valid    = ($urandom_range(7) != 0);
        r.rs       = 4'($urandom_range(3));
        r.rt       = 4'($urandom_range(3));
        r.rd       = 4'($urandom_range(3));
        r.memread  = ($urandom_range(2) == 0);
        r.memwrite = ($urandom_range(3) == 0);
        r.regwrite = 1'($urandom);
        r.memtoreg = 1'($urandom);
        r.alusrc   = 1'($urandom);
        r.halt     = ($urandom_range(15) == 0);
        r.aluop    = 4'($urandom);
        r.rsdata   = 16'($urandom);
        r.rtdata   = 16'($urandom);
        r.imm      = 16'($urandom);
        r.pc       = 16'($urandom);
        return r;
    endfunction

    function automatic instr_t mk(input int rs, input int rt, input int rd, input bit ld, input bit st);
        instr_t r;
        r          = rand_instr();
        r.valid    = 1'b1;
        r.rs       = 4'(rs);
        r.rt       = 4'(rt);
        r.rd       = 4'(rd);
        r.memread  = ld;
        r.memwrite = st;
        r.regwrite = !st;
        r.halt     = 1'b0;
        return r;
    endfunction

    // One clock: apply inputs, sample Stall before the edge, then advance the model.
    task automatic drive_cycle(input instr_t in, input bit rr_s, input bit rr_t,
                               input bit h, input bit f, input bit r);
        @(negedge clk);
        rst = r; Hold = h; Flush = f;
        IF_ID_Valid = in.valid; IF_ID_RegRs = in.rs; IF_ID_RegRt = in.rt; IF_ID_RegRd = in.rd;
        IF_ID_ReadsRs = rr_s; IF_ID_ReadsRt = rr_t;
        ID_RegWrite = in.regwrite; ID_MemRead = in.memread; ID_MemWrite = in.memwrite;
        ID_MemToReg = in.memtoreg; ID_ALUSrc = in.alusrc; ID_Halt = in.halt; ID_ALUOp = in.aluop;
        ID_RsData = in.rsdata; ID_RtData = in.rtdata; ID_Imm = in.imm; ID_PC = in.pc;
        #1;
        exp_stall = model_load_use(m_ex, in, rr_s, rr_t) && !f && !r;
        obs_stall = Stall;
        @(posedge clk);
        #1;
        if (r) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (!h) begin
            if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
            if (f || exp_stall || !in.valid) m_ex = '0;
            else begin
                m_ex       = in;
                m_ex.valid = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        drive_cycle(rand_instr(), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            do_reset();
            tests_run++;
            if (obs_stall !== 1'b0 || dut_ex !== '0 || StallCount !== '0) begin
                failures++;
                $display("FAIL reset[%0d]: got stall=%b ex=%h cnt=%0d want 0/0/0", i, obs_stall, dut_ex, StallCount);
            end
        end
    endtask

    task automatic test_load_use_rs();
        instr_t add;
        do_reset();
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        add = mk(3, 4, 5, 0, 0);
        drive_cycle(add, 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b1 || ID_EX_Valid !== 1'b0 || ID_EX_RegRd !== 4'd0 || StallCount !== CW'(1)) begin
            failures++;
            $display("FAIL lu_rs_stall: got stall=%b valid=%b rd=%0d cnt=%0d want 1/0/0/1", obs_stall, ID_EX_Valid, ID_EX_RegRd, StallCount);
        end
        drive_cycle(add, 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_Valid !== 1'b1 || ID_EX_RegRs !== 4'd3 || ID_EX_RegRd !== 4'd5) begin
            failures++;
            $display("FAIL lu_rs_issue: got stall=%b valid=%b rs=%0d rd=%0d want 0/1/3/5", obs_stall, ID_EX_Valid, ID_EX_RegRs, ID_EX_RegRd);
        end
        tests_run++;
        if (dut_ex !== m_ex || StallCount !== CW'(m_cnt)) begin
            failures++;
            $display("FAIL lu_rs_model: got ex=%h cnt=%0d want ex=%h cnt=%0d", dut_ex, StallCount, m_ex, m_cnt);
        end
    endtask

    task automatic test_store_exempt();
        do_reset();
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        drive_cycle(mk(6, 3, 0, 0, 1), 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_Valid !== 1'b1 || ID_EX_MemWrite !== 1'b1 || ID_EX_RegRt !== 4'd3) begin
            failures++;
            $display("FAIL store_data_nostall: got stall=%b valid=%b memwr=%b rt=%0d want 0/1/1/3", obs_stall, ID_EX_Valid, ID_EX_MemWrite, ID_EX_RegRt);
        end
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        drive_cycle(mk(3, 7, 0, 0, 1), 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b1 || ID_EX_Valid !== 1'b0) begin
            failures++;
            $display("FAIL store_addr_stall: got stall=%b valid=%b want 1/0", obs_stall, ID_EX_Valid);
        end
    endtask

    task automatic test_r0_nonreads();
        do_reset();
        drive_cycle(mk(1, 0, 0, 1, 0), 1, 0, 0, 0, 0);
        drive_cycle(mk(0, 0, 5, 0, 0), 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_Valid !== 1'b1) begin
            failures++;
            $display("FAIL r0_nostall: got stall=%b valid=%b want 0/1", obs_stall, ID_EX_Valid);
        end
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        drive_cycle(mk(3, 3, 5, 0, 0), 0, 0, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_RegRs !== 4'd3 || ID_EX_Valid !== 1'b1) begin
            failures++;
            $display("FAIL nonread_nostall: got stall=%b rs=%0d valid=%b want 0/3/1", obs_stall, ID_EX_RegRs, ID_EX_Valid);
        end
    endtask

    task automatic test_flush_and_reset_mid_stall();
        instr_t add;
        int cnt_before;
        do_reset();
        drive_cycle(mk(3, 3, 5, 0, 0), 1, 0, 0, 0, 0);
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        cnt_before = m_cnt;
        add = mk(3, 4, 5, 0, 0);
        drive_cycle(add, 1, 1, 0, 1, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_Valid !== 1'b0 || ID_EX_RegRd !== 4'd0 || StallCount !== CW'(cnt_before)) begin
            failures++;
            $display("FAIL flush_wins: got stall=%b valid=%b rd=%0d cnt=%0d want 0/0/0/%0d", obs_stall, ID_EX_Valid, ID_EX_RegRd, StallCount, cnt_before);
        end
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        drive_cycle(add, 1, 1, 0, 0, 1);
        tests_run++;
        if (obs_stall !== 1'b0 || dut_ex !== '0 || StallCount !== '0) begin
            failures++;
            $display("FAIL rst_mid_stall: got stall=%b ex=%h cnt=%0d want 0/0/0", obs_stall, dut_ex, StallCount);
        end
        drive_cycle(add, 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_Valid !== 1'b1 || ID_EX_RegRd !== 4'd5) begin
            failures++;
            $display("FAIL rst_no_pending: got stall=%b valid=%b rd=%0d want 0/1/5", obs_stall, ID_EX_Valid, ID_EX_RegRd);
        end
    endtask

    task automatic test_hold();
        instr_t add;
        do_reset();
        drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
        add = mk(3, 4, 5, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(add, 1, 1, 1, 0, 0);
            tests_run++;
            if (obs_stall !== 1'b1 || ID_EX_MemRead !== 1'b1 || ID_EX_RegRd !== 4'd3 || StallCount !== '0) begin
                failures++;
                $display("FAIL hold_freeze[%0d]: got stall=%b memrd=%b rd=%0d cnt=%0d want 1/1/3/0", i, obs_stall, ID_EX_MemRead, ID_EX_RegRd, StallCount);
            end
        end
        drive_cycle(add, 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b1 || ID_EX_Valid !== 1'b0 || StallCount !== CW'(1)) begin
            failures++;
            $display("FAIL hold_release_stall: got stall=%b valid=%b cnt=%0d want 1/0/1", obs_stall, ID_EX_Valid, StallCount);
        end
        drive_cycle(add, 1, 1, 0, 0, 0);
        tests_run++;
        if (obs_stall !== 1'b0 || ID_EX_RegRs !== 4'd3 || ID_EX_Valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_release_issue: got stall=%b rs=%0d valid=%b want 0/3/1", obs_stall, ID_EX_RegRs, ID_EX_Valid);
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        for (int i = 1; i <= CNT_MAX + 3; i++) begin
            drive_cycle(mk(1, 0, 3, 1, 0), 1, 0, 0, 0, 0);
            drive_cycle(mk(2, 3, 4, 1, 0), 1, 1, 0, 0, 0);
            want = (i < CNT_MAX) ? i : CNT_MAX;
            tests_run++;
            if (obs_stall !== 1'b1 || StallCount !== CW'(want)) begin
                failures++;
                $display("FAIL stall_count[%0d]: got stall=%b cnt=%0d want 1/%0d", i, obs_stall, StallCount, want);
            end
            drive_cycle(mk(2, 3, 4, 1, 0), 1, 1, 0, 0, 0);
        end
    endtask

    task automatic test_random();
        instr_t in;
        bit rr_s, rr_t, h, f, r;
        for (int i = 0; i < 400; i++) begin
            in   = rand_instr();
            rr_s = ($urandom_range(3) != 0);
            rr_t = ($urandom_range(1) != 0);
            h    = ($urandom_range(7) == 0);
            f    = ($urandom_range(9) == 0);
            r    = ($urandom_range(49) == 0);
            drive_cycle(in, rr_s, rr_t, h, f, r);
            tests_run++;
            if (obs_stall !== exp_stall || dut_ex !== m_ex || StallCount !== CW'(m_cnt)) begin
                failures++;
                $display("FAIL random[%0d]: got stall=%b ex=%h cnt=%0d want stall=%b ex=%h cnt=%0d",
                         i, obs_stall, dut_ex, StallCount, exp_stall, m_ex, m_cnt);
            end
        end
    endtask

    initial begin
        m_ex = '0; m_cnt = 0; obs_stall = 1'b0; exp_stall = 1'b0;
        rst = 1'b1; Hold = 1'b0; Flush = 1'b0;
        IF_ID_Valid = 1'b0; IF_ID_RegRs = '0; IF_ID_RegRt = '0; IF_ID_RegRd = '0;
        IF_ID_ReadsRs = 1'b0; IF_ID_ReadsRt = 1'b0;
        ID_RegWrite = 1'b0; ID_MemRead = 1'b0; ID_MemWrite = 1'b0; ID_MemToReg = 1'b0;
        ID_ALUSrc = 1'b0; ID_Halt = 1'b0; ID_ALUOp = '0;
        ID_RsData = '0; ID_RtData = '0; ID_Imm = '0; ID_PC = '0;
        test_reset();
        test_load_use_rs();
        test_store_exempt();
        test_r0_nonreads();
        test_flush_and_reset_mid_stall();
        test_hold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 16-bit, 16-register pipelined CPU.
- Includes load-use hazard detection.
- Registers decoded control, operand data and register IDs into EX; these outputs drive the downstream forwarding unit and the ALU.
- Generates the stall that freezes PC and IF/ID, and inserts bubbles on load-use stall or branch flush.
- The load-use check skips the stall when the hazard is only on store data. That case is covered by the MEM-to-MEM forwarding path.

Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_W, 4, register ID width
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- Hold  in  1  global freeze (multi-cycle memory); ID/EX retains contents
- Flush  in  1  branch taken; squash instruction in ID
- IF_ID_Valid  in  1  ID holds a real instruction
- IF_ID_RegRs / IF_ID_RegRt / IF_ID_RegRd  in  REG_W each  decoded register IDs
- IF_ID_ReadsRs / IF_ID_ReadsRt  in  1 each  instruction actually reads Rs/Rt
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_Halt  in  1 each  decoded control
- ID_ALUOp  in  4  ALU operation
- ID_RsData / ID_RtData / ID_Imm / ID_PC  in  DATA_W each  operands, sign-extended immediate, PC+2
- ID_EX_* (Valid, RegRs, RegRt, RegRd, RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Halt, ALUOp, RsData, RtData, Imm, PC)  out  widths as inputs  registered copies
- Stall  out  1  freeze PC and IF/ID this cycle
- StallCount  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset: all ID_EX_* outputs are 0, StallCount is 0, and Stall is 0 during reset.
- Latency: one cycle, ID to ID_EX_*.

LoadUse (combinational from current ID_EX_* and IF_ID_* inputs):
- Base condition: ID_EX_Valid & ID_EX_MemRead & (ID_EX_RegRd != 0) & IF_ID_Valid.
- The base condition ANDs with (RsHit | (RtHit & !StoreData)), where:
  - RsHit = IF_ID_ReadsRs & (IF_ID_RegRs == ID_EX_RegRd)
  - RtHit = IF_ID_ReadsRt & (IF_ID_RegRt == ID_EX_RegRd)
  - StoreData = ID_MemWrite & !RsHit
- A store whose only dependency is its data register (Rt) does not stall.

Stall:
- Stall = LoadUse & !Flush & !rst.
- Flush wins because the dependent instruction is being squashed.
- Hold does not mask Stall; upstream already freezes under Hold.

Register update priority each rising clk:
1. rst: clear everything.
2. Hold: all ID_EX_* and StallCount unchanged; Flush and LoadUse have no effect this cycle.
3. Flush or Stall: bubble. All ID_EX_* are written to 0, including RegRd = 0 so the forwarding unit ignores it, Valid = 0 and Halt = 0.
4. IF_ID_Valid = 0: bubble, same as item 3.
5. Otherwise: capture all ID_* / IF_ID_* inputs, with Valid = 1.

StallCount:
- Increments by 1 on each non-Hold cycle with Stall = 1.
- Saturates at all-ones and never wraps.

Further rules:
- A load-use stall lasts exactly one cycle. The bubble clears ID_EX_MemRead, so LoadUse deasserts next cycle and the held instruction then issues.
- Back-to-back loads that each feed the next instruction stall one cycle each.
- Halt: ID_Halt passes through like any control bit. Stall and Flush squash it.
- rst asserted mid-stall: next cycle all outputs are 0 and no stall remains pending.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all ID_EX_* = 0, StallCount = 0, Stall = 0.
- Load-use on Rs: LW R3 in EX, ADD R5,R3,R4 in ID -> Stall = 1 for one cycle, bubble (RegRd = 0, Valid = 0), then ADD captured with RegRs = 3 next cycle, StallCount = 1.
- Store-data exemption: LW R3 in EX, SW R3,[R6] in ID (Rt = 3, Rs = 6) -> Stall = 0, SW captured immediately. Same with SW R7,[R3] (Rs = 3) -> Stall = 1.
- R0 and non-reads: LW R0 followed by a consumer of R0 -> no stall. LW R3 followed by an instruction with ReadsRs = ReadsRt = 0 but RegRs = 3 -> no stall.
- Flush vs stall: load-use condition with Flush = 1 in the same cycle -> Stall = 0, bubble inserted, StallCount unchanged.
- Hold: Hold = 1 for 3 cycles with a load-use condition present -> ID_EX_* and StallCount frozen. Drop Hold -> single stall bubble, then issue. Preset StallCount to all-ones, then stall -> it stays all-ones.
